level_timer_ctrl: RTL and testbench

Level-clock controller for the game. It consumes the single-cycle 1 ms tick from the tick generator and sequences it into a 3-digit BCD level countdown with start/pause/resume/abort control, time bonuses, a low-time warning and expiry signalling. It also produces a periodic frame strobe for the renderer and the physics logic. It sits between the tick generator and the game FSM and HUD.

---
 rtl/level_timer_pkg.sv | 32 +++
 rtl/bcd3_step.sv | 32 +++
 rtl/level_timer_ctrl.sv | 155 +++++++++++++++
 tb/tb_level_timer_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/level_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : level_timer_pkg
// Description : Shared types, constants and BCD helpers for the level clock.
// Revision    : 1.0 - initial release
// ============================================================================
package level_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam logic [11:0] c_BCD_MAX = 12'h999;

    // Also used on elaboration-time parameters to build BCD constants.
    function automatic logic [11:0] to_bcd3(input int unsigned v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [9:0] bcd3_to_bin(input logic [11:0] b);
        return 10'(b[11:8]) * 10'd100 + 10'(b[7:4]) * 10'd10 + 10'(b[3:0]);
    endfunction

    function automatic logic bcd2_valid(input logic [7:0] b);
        return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd3_step.sv
`default_nettype none
// ============================================================================
// Module      : bcd3_step
// Description : 3-digit BCD value, optional -1 and 2-digit BCD add, clamped
//               to 000..999, with a zero flag on the result.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd3_step
    import level_timer_pkg::*;
(
    input  logic [11:0] i_value,
    input  logic        i_dec_en,
    input  logic [7:0]  i_add_bcd,
    output logic [11:0] o_result,
    output logic        o_zero
);

    logic [10:0] w_sum;
    logic [9:0]  w_sat;

    always_comb begin
        w_sum = {1'b0, bcd3_to_bin(i_value)} + {1'b0, bcd3_to_bin({4'h0, i_add_bcd})};
        if (i_dec_en && (w_sum != 11'd0)) begin
            w_sum = w_sum - 11'd1;
        end
        w_sat    = (w_sum > 11'(bcd3_to_bin(c_BCD_MAX))) ? bcd3_to_bin(c_BCD_MAX) : w_sum[9:0];
        o_result = to_bcd3(32'(w_sat));
        o_zero   = (o_result == 12'h000);
    end

endmodule
`default_nettype wire

// File: rtl/level_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : level_timer_ctrl
// Description : Level countdown in BCD seconds with run/pause control,
//               bonuses, low-time warning, expiry and a frame strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module level_timer_ctrl #(
    parameter int TICKS_PER_SEC = 1000,
    parameter int START_SECS    = 400,
    parameter int WARN_SECS     = 100,
    parameter int FRAME_MS      = 16
) (
    input  logic        mclk,
    input  logic        rst,
    input  logic        tick_1ms,
    input  logic        start,
    input  logic        pause,
    input  logic        resume,
    input  logic        abort,
    input  logic        bonus_req,
    input  logic [7:0]  bonus_bcd,
    output logic [11:0] secs_bcd,
    output logic [1:0]  state,
    output logic        warn,
    output logic        expired,
    output logic        expire_pulse,
    output logic        sec_pulse,
    output logic        frame_pulse
);
    import level_timer_pkg::*;

    localparam int c_MSW = $clog2(TICKS_PER_SEC);
    localparam int c_FW  = (FRAME_MS > 1) ? $clog2(FRAME_MS) : 1;
    localparam logic [11:0]      c_START_BCD  = to_bcd3(START_SECS);
    localparam logic [11:0]      c_WARN_BCD   = to_bcd3(WARN_SECS);
    localparam logic [c_MSW-1:0] c_MS_LAST    = c_MSW'(TICKS_PER_SEC - 1);
    localparam logic [c_FW-1:0]  c_FRAME_LAST = c_FW'(FRAME_MS - 1);

    state_t            r_state, w_state_n;
    logic [11:0]       r_secs, w_secs_n;
    logic [c_MSW-1:0]  r_ms_cnt, w_ms_n;
    logic [c_FW-1:0]   r_frame_cnt;
    logic              r_warn, w_warn_n;
    logic              r_expired, w_expired_n;
    logic              r_expire_pulse, w_expire_pulse_n;
    logic              r_sec_pulse, w_sec_pulse_n;
    logic              r_frame_pulse;

    logic              w_tick_run, w_dec, w_bonus_ok, w_step_zero;
    logic [7:0]        w_add;
    logic [11:0]       w_step;

    // A tick counts only when no abort/start/pause claims the cycle.
    assign w_tick_run = (r_state == ST_RUN) && tick_1ms && !abort && !start && !pause;
    assign w_dec      = w_tick_run && (r_ms_cnt == c_MS_LAST);
    assign w_bonus_ok = bonus_req && bcd2_valid(bonus_bcd)
                        && ((r_state == ST_RUN) || (r_state == ST_PAUSE));
    assign w_add      = w_bonus_ok ? bonus_bcd : 8'h00;

    bcd3_step u_step (
        .i_value   (r_secs),
        .i_dec_en  (w_dec),
        .i_add_bcd (w_add),
        .o_result  (w_step),
        .o_zero    (w_step_zero)
    );

    always_comb begin
        w_state_n        = r_state;
        w_secs_n         = r_secs;
        w_ms_n           = r_ms_cnt;
        w_sec_pulse_n    = 1'b0;
        w_expire_pulse_n = 1'b0;
        if (abort) begin
            w_state_n = ST_IDLE;
            w_secs_n  = c_START_BCD;
            w_ms_n    = '0;
        end else if (start) begin
            w_state_n = ST_RUN;
            w_secs_n  = c_START_BCD;
            w_ms_n    = '0;
        end else begin
            if ((r_state == ST_RUN) && pause) begin
                w_state_n = ST_PAUSE;
            end else if ((r_state == ST_PAUSE) && resume) begin
                w_state_n = ST_RUN;
            end
            if (w_tick_run) begin
                w_ms_n = w_dec ? '0 : r_ms_cnt + 1'b1;
            end
            if (w_dec || w_bonus_ok) begin
                w_secs_n = w_step;
            end
            // Expiry is judged after any coincident bonus has been added.
            if (w_dec) begin
                w_sec_pulse_n = 1'b1;
                if (w_step_zero) begin
                    w_state_n        = ST_EXPIRED;
                    w_expire_pulse_n = 1'b1;
                end
            end
        end
        w_warn_n    = ((w_state_n == ST_RUN) || (w_state_n == ST_PAUSE)) && (w_secs_n <= c_WARN_BCD);
        w_expired_n = (w_state_n == ST_EXPIRED);
    end

    always_ff @(posedge mclk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_secs         <= c_START_BCD;
            r_ms_cnt       <= '0;
            r_warn         <= 1'b0;
            r_expired      <= 1'b0;
            r_expire_pulse <= 1'b0;
            r_sec_pulse    <= 1'b0;
        end else begin
            r_state        <= w_state_n;
            r_secs         <= w_secs_n;
            r_ms_cnt       <= w_ms_n;
            r_warn         <= w_warn_n;
            r_expired      <= w_expired_n;
            r_expire_pulse <= w_expire_pulse_n;
            r_sec_pulse    <= w_sec_pulse_n;
        end
    end

    // Frame strobe free-runs in every state so menus keep animating.
    always_ff @(posedge mclk) begin
        if (rst) begin
            r_frame_cnt   <= '0;
            r_frame_pulse <= 1'b0;
        end else begin
            r_frame_pulse <= 1'b0;
            if (tick_1ms) begin
                if (r_frame_cnt == c_FRAME_LAST) begin
                    r_frame_cnt   <= '0;
                    r_frame_pulse <= 1'b1;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
        end
    end

    assign secs_bcd     = r_secs;
    assign state        = r_state;
    assign warn         = r_warn;
    assign expired      = r_expired;
    assign expire_pulse = r_expire_pulse;
    assign sec_pulse    = r_sec_pulse;
    assign frame_pulse  = r_frame_pulse;

endmodule
`default_nettype wire

// File: tb/tb_level_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_level_timer_ctrl
// Description : Directed scenarios plus random traffic against a decimal
//               reference model, on three differently parameterised timers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_level_timer_ctrl;

    localparam int c_TPS   = 4;
    localparam int c_FRAME = 2;
    localparam int c_N     = 3;

    logic       mclk = 1'b0;
    logic       rst, tick, start, pause, resume, abort, bonus_req;
    logic [7:0] bonus_bcd;

    logic [11:0] w_secs    [c_N];
    logic [1:0]  w_state   [c_N];
    logic        w_warn    [c_N];
    logic        w_expired [c_N];
    logic        w_expp    [c_N];
    logic        w_secp    [c_N];
    logic        w_framep  [c_N];

    int m_start[c_N], m_warnlim[c_N];
    int m_state[c_N], m_secs[c_N], m_ms[c_N], m_frame[c_N];
    bit m_warn[c_N], m_exp[c_N], m_expp[c_N], m_secp[c_N], m_framep[c_N];

    int n_checks = 0;
    int n_errors = 0;

    always #5 mclk = ~mclk;

    level_timer_ctrl #(.TICKS_PER_SEC(c_TPS), .START_SECS(3), .WARN_SECS(2), .FRAME_MS(c_FRAME)) u_dut0 (
        .mclk(mclk), .rst(rst), .tick_1ms(tick), .start(start), .pause(pause), .resume(resume),
        .abort(abort), .bonus_req(bonus_req), .bonus_bcd(bonus_bcd), .secs_bcd(w_secs[0]),
        .state(w_state[0]), .warn(w_warn[0]), .expired(w_expired[0]), .expire_pulse(w_expp[0]),
        .sec_pulse(w_secp[0]), .frame_pulse(w_framep[0]));

    level_timer_ctrl #(.TICKS_PER_SEC(c_TPS), .START_SECS(990), .WARN_SECS(100), .FRAME_MS(c_FRAME)) u_dut1 (
        .mclk(mclk), .rst(rst), .tick_1ms(tick), .start(start), .pause(pause), .resume(resume),
        .abort(abort), .bonus_req(bonus_req), .bonus_bcd(bonus_bcd), .secs_bcd(w_secs[1]),
        .state(w_state[1]), .warn(w_warn[1]), .expired(w_expired[1]), .expire_pulse(w_expp[1]),
        .sec_pulse(w_secp[1]), .frame_pulse(w_framep[1]));

    level_timer_ctrl #(.TICKS_PER_SEC(c_TPS), .START_SECS(100), .WARN_SECS(100), .FRAME_MS(c_FRAME)) u_dut2 (
        .mclk(mclk), .rst(rst), .tick_1ms(tick), .start(start), .pause(pause), .resume(resume),
        .abort(abort), .bonus_req(bonus_req), .bonus_bcd(bonus_bcd), .secs_bcd(w_secs[2]),
        .state(w_state[2]), .warn(w_warn[2]), .expired(w_expired[2]), .expire_pulse(w_expp[2]),
        .sec_pulse(w_secp[2]), .frame_pulse(w_framep[2]));

    function automatic logic [11:0] to_bcd(input int v);
        logic [3:0] h, t, o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    // Decimal-seconds model of the level clock, evaluated at each rising edge.
    task automatic model_step();
        int bval;
        bit bvalid, acc, ticking, dec;
        bval   = 10 * int'(bonus_bcd[7:4]) + int'(bonus_bcd[3:0]);
        bvalid = (bonus_bcd[7:4] < 4'd10) && (bonus_bcd[3:0] < 4'd10);
        for (int k = 0; k < c_N; k++) begin
            if (rst) begin
                m_state[k] = 0; m_secs[k] = m_start[k]; m_ms[k] = 0; m_frame[k] = 0;
                m_warn[k] = 0; m_exp[k] = 0; m_expp[k] = 0; m_secp[k] = 0; m_framep[k] = 0;
            end else begin
                m_secp[k] = 0; m_expp[k] = 0; m_framep[k] = 0;
                if (tick) begin
                    if (m_frame[k] == c_FRAME - 1) begin
                        m_frame[k] = 0; m_framep[k] = 1;
                    end else begin
                        m_frame[k] = m_frame[k] + 1;
                    end
                end
                if (abort) begin
                    m_state[k] = 0; m_secs[k] = m_start[k]; m_ms[k] = 0;
                end else if (start) begin
                    m_state[k] = 1; m_secs[k] = m_start[k]; m_ms[k] = 0;
                end else begin
                    acc     = bonus_req && bvalid && (m_state[k] == 1 || m_state[k] == 2);
                    ticking = (m_state[k] == 1) && tick && !pause;
                    if (m_state[k] == 1 && pause) m_state[k] = 2;
                    else if (m_state[k] == 2 && resume) m_state[k] = 1;
                    dec = 0;
                    if (ticking) begin
                        if (m_ms[k] == c_TPS - 1) begin
                            m_ms[k] = 0; dec = 1;
                        end else begin
                            m_ms[k] = m_ms[k] + 1;
                        end
                    end
                    if (dec) m_secs[k] = m_secs[k] - 1;
                    if (acc) m_secs[k] = m_secs[k] + bval;
                    if (m_secs[k] > 999) m_secs[k] = 999;
                    if (dec) begin
                        m_secp[k] = 1;
                        if (m_secs[k] == 0) begin
                            m_state[k] = 3; m_expp[k] = 1;
                        end
                    end
                end
                m_warn[k] = (m_state[k] == 1 || m_state[k] == 2) && (m_secs[k] <= m_warnlim[k]);
                m_exp[k]  = (m_state[k] == 3);
            end
        end
    endtask

    task automatic clk1();
        @(posedge mclk);
        model_step();
        #1;
    endtask

    task automatic cyc(input bit i_tick, input bit i_start, input bit i_pause, input bit i_resume,
                       input bit i_abort, input bit i_breq, input logic [7:0] i_bb);
        tick = i_tick; start = i_start; pause = i_pause; resume = i_resume;
        abort = i_abort; bonus_req = i_breq; bonus_bcd = i_bb;
        clk1();
        tick = 0; start = 0; pause = 0; resume = 0; abort = 0; bonus_req = 0; bonus_bcd = 8'h00;
    endtask

    task automatic test_reset();
        rst = 1;
        cyc(0, 0, 0, 0, 0, 0, 8'h00);
        cyc(1, 1, 0, 0, 0, 1, 8'h11);
        rst = 0;
        for (int k = 0; k < c_N; k++) begin
            n_checks++;
            if ({w_state[k], w_secs[k], w_warn[k], w_expired[k], w_expp[k], w_secp[k], w_framep[k]}
                !== {2'd0, to_bcd(m_start[k]), 5'b0}) begin
                n_errors++;
                $display("FAIL reset[%0d]: state=%0d secs=%h flags=%b%b%b%b%b, want state=0 secs=%h flags=00000",
                         k, w_state[k], w_secs[k], w_warn[k], w_expired[k], w_expp[k], w_secp[k], w_framep[k],
                         to_bcd(m_start[k]));
            end
        end
    endtask

    task automatic test_countdown();
        cyc(1, 0, 0, 0, 0, 0, 8'h00);
        n_checks++;
        if (w_framep[0] !== 1'b0) begin
            n_errors++; $display("FAIL idle_frame1: frame_pulse=%b want 0", w_framep[0]);
        end
        cyc(1, 0, 0, 0, 0, 0, 8'h00);
        n_checks++;
        if (w_framep[0] !== 1'b1) begin
            n_errors++; $display("FAIL idle_frame2: frame_pulse=%b want 1", w_framep[0]);
        end
        cyc(0, 1, 0, 0, 0, 0, 8'h00);
        n_checks++;
        if ({w_state[0], w_secs[0], w_warn[0]} !== {2'd1, 12'h003, 1'b0}) begin
            n_errors++; $display("FAIL start: state=%0d secs=%h warn=%b want 1/003/0", w_state[0], w_secs[0], w_warn[0]);
        end
        for (int i = 1; i <= 12; i++) begin
            for (int j = 0; j < 4; j++) begin
                cyc(0, 0, 0, 0, 0, 0, 8'h00);
                n_checks++;
                if ({w_secp[0], w_framep[0], w_expp[0]} !== 3'b000) begin
                    n_errors++; $display("FAIL gap_pulses t%0d: sec/frame/exp=%b%b%b want 000", i, w_secp[0], w_framep[0], w_expp[0]);
                end
            end
            cyc(1, 0, 0, 0, 0, 0, 8'h00);
            n_checks++;
            if ({w_state[0], w_secs[0], w_warn[0], w_expired[0], w_expp[0], w_secp[0], w_framep[0]}
                !== {(i == 12) ? 2'd3 : 2'd1, to_bcd(3 - i / 4), (i >= 4 && i < 12), (i == 12), (i == 12),
                     (i % 4 == 0), (i % 2 == 0)}) begin
                n_errors++;
                $display("FAIL countdown t%0d: state=%0d secs=%h warn/exp/expp/secp/frm=%b%b%b%b%b",
                         i, w_state[0], w_secs[0], w_warn[0], w_expired[0], w_expp[0], w_secp[0], w_framep[0]);
            end
        end
        cyc(0, 0, 0, 0, 0, 0, 8'h00);
        n_checks++;
        if ({w_state[0], w_expired[0], w_expp[0]} !== {2'd3, 1'b1, 1'b0}) begin
            n_errors++; $display("FAIL expired_hold: state=%0d expired=%b expire_pulse=%b want 3/1/0",
                                 w_state[0], w_expired[0], w_expp[0]);
        end
    endtask

    task automatic test_pause();
        cyc(0, 1, 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 8'h00);
        cyc(0, 0, 1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 0, 0, 0, 0, 8'h00);
            n_checks++;
            if ({w_state[0], w_secs[0], w_secp[0]} !== {2'd2, 12'h003, 1'b0}) begin
                n_errors++; $display("FAIL paused %0d: state=%0d secs=%h sec_pulse=%b want 2/003/0",
                                     i, w_state[0], w_secs[0], w_secp[0]);
            end
        end
        cyc(0, 0, 0, 1, 0, 0, 8'h00);
        cyc(1, 0, 0, 0, 0, 0, 8'h00);
        n_checks++;
        if ({w_state[0], w_secs[0], w_secp[0]} !== {2'd1, 12'h002, 1'b1}) begin
            n_errors++; $display("FAIL resume_retain: state=%0d secs=%h sec_pulse=%b want 1/002/1",
                                 w_state[0], w_secs[0], w_secp[0]);
        end
    endtask

    task automatic test_coincide();
        cyc(0, 1, 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 8'h00);
        cyc(1, 0, 1, 0, 0, 0, 8'h00);
        n_checks++;
        if ({w_state[0], w_secs[0], w_secp[0]} !== {2'd2, 12'h003, 1'b0}) begin
            n_errors++; $display("FAIL tick_pause: state=%0d secs=%h sec_pulse=%b want 2/003/0",
                                 w_state[0], w_secs[0], w_secp[0]);
        end
        cyc(0, 0, 0, 1, 0, 0, 8'h00);
        cyc(1, 0, 0, 0, 0, 0, 8'h00);
        n_checks++;
        if ({w_secs[0], w_secp[0]} !== {12'h002, 1'b1}) begin
            n_errors++; $display("FAIL after_tick_pause: secs=%h sec_pulse=%b want 002/1", w_secs[0], w_secp[0]);
        end
        cyc(1, 1, 0, 0, 1, 0, 8'h00);
        n_checks++;
        if ({w_state[0], w_secs[0]} !== {2'd0, 12'h003}) begin
            n_errors++; $display("FAIL start_abort: state=%0d secs=%h want 0/003", w_state[0], w_secs[0]);
        end
    endtask

    task automatic test_bonus();
        cyc(0, 1, 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 11; i++) cyc(1, 0, 0, 0, 0, 0, 8'h00);
        n_checks++;
        if ({w_secs[0], w_warn[0]} !== {12'h001, 1'b1}) begin
            n_errors++; $display("FAIL bonus_setup: secs=%h warn=%b want 001/1", w_secs[0], w_warn[0]);
        end
        cyc(1, 0, 0, 0, 0, 1, 8'h05);
        n_checks++;
        if ({w_state[0], w_secs[0], w_secp[0], w_expp[0], w_expired[0], w_warn[0]}
            !== {2'd1, 12'h005, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_errors++; $display("FAIL bonus_rescue: state=%0d secs=%h secp/expp/exp/warn=%b%b%b%b want 1/005/1000",
                                 w_state[0], w_secs[0], w_secp[0], w_expp[0], w_expired[0], w_warn[0]);
        end
        cyc(0, 0, 0, 0, 0, 1, 8'h1A);
        n_checks++;
        if (w_secs[0] !== 12'h005) begin
            n_errors++; $display("FAIL bonus_nonbcd: secs=%h want 005", w_secs[0]);
        end
        cyc(0, 0, 0, 0, 1, 0, 8'h00);
        cyc(0, 0, 0, 0, 0, 1, 8'h05);
        n_checks++;
        if ({w_state[0], w_secs[0]} !== {2'd0, 12'h003}) begin
            n_errors++; $display("FAIL bonus_idle: state=%0d secs=%h want 0/003", w_state[0], w_secs[0]);
        end
        cyc(0, 1, 0, 0, 0, 0, 8'h00);
        cyc(0, 0, 0, 0, 0, 1, 8'h50);
        n_checks++;
        if ({w_secs[1], w_secs[0]} !== {12'h999, 12'h053}) begin
            n_errors++; $display("FAIL bonus_sat: secs1=%h secs0=%h want 999/053", w_secs[1], w_secs[0]);
        end
    endtask

    task automatic test_borrow();
        cyc(0, 1, 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 0, 8'h00);
        n_checks++;
        if ({w_secs[2], w_warn[2], w_secp[2]} !== {12'h099, 1'b1, 1'b1}) begin
            n_errors++; $display("FAIL borrow: secs=%h warn=%b sec_pulse=%b want 099/1/1", w_secs[2], w_warn[2], w_secp[2]);
        end
    endtask

    task automatic test_rst_mid();
        cyc(0, 0, 0, 0, 1, 0, 8'h00);
        for (int g = 0; g < 4 && m_frame[0] != 1; g++) cyc(1, 0, 0, 0, 0, 0, 8'h00);
        cyc(0, 1, 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 0, 0, 8'h00);
        n_checks++;
        if ({w_state[0], w_secs[0]} !== {2'd1, 12'h002}) begin
            n_errors++; $display("FAIL rst_setup: state=%0d secs=%h want 1/002", w_state[0], w_secs[0]);
        end
        rst = 1;
        cyc(1, 0, 0, 0, 0, 1, 8'h05);
        rst = 0;
        n_checks++;
        if ({w_state[0], w_secs[0], w_warn[0], w_expired[0], w_expp[0], w_secp[0], w_framep[0]}
            !== {2'd0, 12'h003, 5'b0}) begin
            n_errors++; $display("FAIL rst_mid: state=%0d secs=%h flags=%b%b%b%b%b want 0/003/00000",
                                 w_state[0], w_secs[0], w_warn[0], w_expired[0], w_expp[0], w_secp[0], w_framep[0]);
        end
        cyc(1, 0, 0, 0, 0, 0, 8'h00);
        n_checks++;
        if (w_framep[0] !== 1'b0) begin
            n_errors++; $display("FAIL rst_frame1: frame_pulse=%b want 0", w_framep[0]);
        end
        cyc(1, 0, 0, 0, 0, 0, 8'h00);
        n_checks++;
        if (w_framep[0] !== 1'b1) begin
            n_errors++; $display("FAIL rst_frame2: frame_pulse=%b want 1", w_framep[0]);
        end
    endtask

    task automatic test_random();
        logic [7:0] bb;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 1) == 0) bb = 8'($urandom_range(0, 255));
            else bb = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            cyc($urandom_range(0, 1) == 1, $urandom_range(0, 79) == 0, $urandom_range(0, 14) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 149) == 0, $urandom_range(0, 19) == 0, bb);
            rst = 0;
            for (int k = 0; k < c_N; k++) begin
                n_checks++;
                if ({w_state[k], w_secs[k], w_warn[k], w_expired[k], w_expp[k], w_secp[k], w_framep[k]}
                    !== {2'(m_state[k]), to_bcd(m_secs[k]), m_warn[k], m_exp[k], m_expp[k], m_secp[k], m_framep[k]}) begin
                    n_errors++;
                    $display("FAIL random c%0d dut%0d: state=%0d secs=%h flags=%b%b%b%b%b want state=%0d secs=%h flags=%b%b%b%b%b",
                             c, k, w_state[k], w_secs[k], w_warn[k], w_expired[k], w_expp[k], w_secp[k], w_framep[k],
                             m_state[k], to_bcd(m_secs[k]), m_warn[k], m_exp[k], m_expp[k], m_secp[k], m_framep[k]);
                end
            end
        end
    endtask

    initial begin
        m_start   = '{3, 990, 100};
        m_warnlim = '{2, 100, 100};
        rst = 1; tick = 0; start = 0; pause = 0; resume = 0; abort = 0; bonus_req = 0; bonus_bcd = 8'h00;
        test_reset();
        test_countdown();
        test_pause();
        test_coincide();
        test_bonus();
        test_borrow();
        test_rst_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
